rtable_arb: RTL and testbench

RTABLE_ARB -- requirements
Module: rtable_arb

---
 rtl/rtable_arb.sv | 103 ++++++++++
 tb/tb_rtable_arb.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/rtable_arb.sv
// Two-requester round-robin front end for the reward table: grants one lookup at a
// time, drives the table address/read strobe, captures the reward word and returns it.
module rtable_arb #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req0_valid,
    input  logic [ADDR_WIDTH-1:0] i_req0_addr,
    output logic                  o_req0_ready,
    input  logic                  i_req1_valid,
    input  logic [ADDR_WIDTH-1:0] i_req1_addr,
    output logic                  o_req1_ready,
    output logic                  o_rsp0_valid,
    output logic                  o_rsp1_valid,
    input  logic                  i_rsp0_ready,
    input  logic                  i_rsp1_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_data,
    output logic [ADDR_WIDTH-1:0] o_tbl_addr,
    output logic                  o_tbl_read,
    input  logic [DATA_WIDTH-1:0] i_tbl_data,
    output logic                  o_busy
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t state;
    logic   ptr;
    logic   gnt_id;
    logic   tbl_read_q;
    logic   rsp0_q;
    logic   rsp1_q;
    logic   busy_q;
    logic   gnt0;
    logic   gnt1;
    logic   rsp_done;

    // ptr names the requester that wins a tie; a lone requester always wins
    always_comb begin
        gnt0 = (state == IDLE) && i_rst_n && i_req0_valid && (!i_req1_valid || !ptr);
        gnt1 = (state == IDLE) && i_rst_n && i_req1_valid && (!i_req0_valid || ptr);
        rsp_done = gnt_id ? i_rsp1_ready : i_rsp0_ready;
    end

    assign o_req0_ready = gnt0;
    assign o_req1_ready = gnt1;

    // Status flags are masked while reset is held so an aborted lookup never shows a response
    assign o_tbl_read   = tbl_read_q & i_rst_n;
    assign o_rsp0_valid = rsp0_q & i_rst_n;
    assign o_rsp1_valid = rsp1_q & i_rst_n;
    assign o_busy       = busy_q & i_rst_n;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            ptr        <= 1'b0;
            gnt_id     <= 1'b0;
            o_tbl_addr <= '0;
            o_rsp_data <= '0;
            tbl_read_q <= 1'b0;
            rsp0_q     <= 1'b0;
            rsp1_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        state      <= ADDR;
                        gnt_id     <= gnt1;
                        ptr        <= gnt0;
                        o_tbl_addr <= gnt1 ? i_req1_addr : i_req0_addr;
                        tbl_read_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                ADDR: begin
                    state      <= DATA;
                    tbl_read_q <= 1'b0;
                end
                DATA: begin
                    state      <= RESP;
                    o_rsp_data <= i_tbl_data;
                    rsp0_q     <= !gnt_id;
                    rsp1_q     <= gnt_id;
                end
                RESP: begin
                    if (rsp_done) begin
                        state  <= IDLE;
                        rsp0_q <= 1'b0;
                        rsp1_q <= 1'b0;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rtable_arb.sv
// Bench for rtable_arb: behavioural reward table behind the arbiter, directed scenarios
// followed by randomized traffic, all checked cycle by cycle against a transaction model.
module tb_rtable_arb;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [8:0]  req0_addr, req1_addr;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready, rsp1_ready;
    logic [31:0] rsp_data;
    logic [8:0]  tbl_addr;
    logic        tbl_read;
    logic [31:0] tbl_data;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    rtable_arb #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0_valid(req0_valid), .i_req0_addr(req0_addr), .o_req0_ready(req0_ready),
        .i_req1_valid(req1_valid), .i_req1_addr(req1_addr), .o_req1_ready(req1_ready),
        .o_rsp0_valid(rsp0_valid), .o_rsp1_valid(rsp1_valid),
        .i_rsp0_ready(rsp0_ready), .i_rsp1_ready(rsp1_ready),
        .o_rsp_data(rsp_data), .o_tbl_addr(tbl_addr), .o_tbl_read(tbl_read),
        .i_tbl_data(tbl_data), .o_busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] tbl_val(input logic [8:0] a);
        case (a)
            9'b110_111_100: return 32'h437F0000;
            9'b000_011_000: return 32'hC37F0000;
            9'b011_011_011: return 32'h00000000;
            default:        return 32'h3F800000 + {23'd0, a} * 32'h00012345;
        endcase
    endfunction

    // Table: registered read one cycle after the address is sampled; junk otherwise
    always @(posedge clk) tbl_data <= tbl_read ? tbl_val(tbl_addr) : $urandom;

    // Transaction-level reference: in flight or not, cycles since grant, who, what
    logic        m_busy = 1'b0;
    int          m_age  = 0;
    logic        m_id   = 1'b0;
    logic        m_ptr  = 1'b0;
    logic [8:0]  m_addr = '0;
    logic [31:0] m_data = '0;

    int          glog_id[$];
    int          glog_cyc[$];
    int          vlog_cyc[$];
    logic [31:0] rlog[$];
    int          n_rv;
    logic        prev_rv = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        glog_id.delete(); glog_cyc.delete(); vlog_cyc.delete(); rlog.delete();
        n_rv = 0;
    endtask

    task automatic step(input logic v0, input logic [8:0] a0, input logic v1,
                        input logic [8:0] a1, input logic r0, input logic r1, input logic rst);
        logic e_g0, e_g1, e_rd, e_bz, e_v0, e_v1, rv;
        @(negedge clk);
        req0_valid = v0; req0_addr = a0; req1_valid = v1; req1_addr = a1;
        rsp0_ready = r0; rsp1_ready = r1; rst_n = rst;
        #1;
        e_g0 = !m_busy && rst && v0 && (!v1 || !m_ptr);
        e_g1 = !m_busy && rst && v1 && (!v0 || m_ptr);
        e_rd = rst && m_busy && (m_age == 1);
        e_bz = rst && m_busy;
        e_v0 = rst && m_busy && (m_age >= 3) && !m_id;
        e_v1 = rst && m_busy && (m_age >= 3) && m_id;
        chk("req0_ready", 32'(req0_ready), 32'(e_g0));
        chk("req1_ready", 32'(req1_ready), 32'(e_g1));
        chk("tbl_read",   32'(tbl_read),   32'(e_rd));
        chk("busy",       32'(busy),       32'(e_bz));
        chk("rsp0_valid", 32'(rsp0_valid), 32'(e_v0));
        chk("rsp1_valid", 32'(rsp1_valid), 32'(e_v1));
        chk("tbl_addr",   32'(tbl_addr),   32'(m_addr));
        chk("rsp_data",   rsp_data,        m_data);
        if (req0_ready) begin glog_id.push_back(0); glog_cyc.push_back(cyc); end
        if (req1_ready) begin glog_id.push_back(1); glog_cyc.push_back(cyc); end
        rv = rsp0_valid | rsp1_valid;
        if (rv) n_rv++;
        if (rv && !prev_rv) vlog_cyc.push_back(cyc);
        prev_rv = rv;
        if ((rsp0_valid && r0) || (rsp1_valid && r1)) rlog.push_back(rsp_data);
        @(posedge clk);
        cyc++;
        if (!rst) begin
            m_busy = 1'b0; m_ptr = 1'b0; m_addr = '0; m_data = '0;
        end else if (!m_busy) begin
            if (e_g0 || e_g1) begin
                m_busy = 1'b1; m_age = 1; m_id = e_g1;
                m_addr = e_g1 ? a1 : a0;
                m_ptr  = e_g0;
            end
        end else begin
            if (m_age == 2) m_data = tbl_val(m_addr);
            if (m_age >= 3 && (m_id ? r1 : r0)) m_busy = 1'b0;
            else if (m_age < 3) m_age++;
        end
    endtask

    localparam logic [8:0] A_HI  = 9'b110_111_100;
    localparam logic [8:0] A_NEG = 9'b000_011_000;
    localparam logic [8:0] A_ZER = 9'b011_011_011;

    initial begin
        req0_valid = 0; req1_valid = 0; req0_addr = 0; req1_addr = 0;
        rsp0_ready = 0; rsp1_ready = 0; rst_n = 0;

        // Reset and first idle cycle
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);

        // Single lookup, latency and value
        clear_logs();
        step(1, A_HI, 0, 0, 1, 1, 1);
        for (int i = 0; i < 5; i++) step(0, 9'h1FF, 0, 0, 1, 1, 1);
        chk("single_ngrant", glog_id.size(), 1);
        chk("single_latency", vlog_cyc[0] - glog_cyc[0], 3);
        chk("single_data", rlog[0], 32'h437F0000);

        // Simultaneous requests straight after reset
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        clear_logs();
        for (int i = 0; i < 8; i++) step(1, A_NEG, 1, A_ZER, 1, 1, 1);
        chk("tie_ngrant", glog_id.size(), 2);
        chk("tie_first", glog_id[0], 0);
        chk("tie_second", glog_id[1], 1);
        chk("tie_gap", glog_cyc[1] - glog_cyc[0], 4);
        chk("tie_data0", rlog[0], 32'hC37F0000);
        chk("tie_data1", rlog[1], 32'h00000000);

        // Both held valid: six alternating grants
        clear_logs();
        for (int i = 0; i < 24; i++) step(1, 9'(i), 1, 9'(i + 100), 1, 1, 1);
        chk("alt_ngrant", glog_id.size(), 6);
        for (int i = 0; i < 6; i++) chk("alt_order", glog_id[i], i % 2);

        // Response back-pressure on requester 1 while requester 0 waits
        clear_logs();
        step(0, 0, 1, A_ZER, 1, 0, 1);
        for (int i = 0; i < 7; i++) step(1, A_HI, 1, 9'h055, 1, 0, 1);
        step(1, A_HI, 0, 0, 1, 1, 1);
        step(1, A_HI, 0, 0, 1, 1, 1);
        chk("bp_ngrant", glog_id.size(), 2);
        chk("bp_first", glog_id[0], 1);
        chk("bp_second", glog_id[1], 0);
        chk("bp_gap", glog_cyc[1] - glog_cyc[0], 9);
        chk("bp_valid_cycles", n_rv, 6);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 1, 1);

        // Reset pulsed while the table data is being captured
        clear_logs();
        step(1, A_HI, 0, 0, 1, 1, 1);
        step(0, 0, 0, 0, 1, 1, 1);
        step(0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 1, 1, 1);
        chk("abort_no_rsp", n_rv, 0);
        clear_logs();
        for (int i = 0; i < 4; i++) step(1, A_NEG, 1, A_ZER, 1, 1, 1);
        chk("abort_next_id", glog_id[0], 0);
        chk("abort_next_data", rlog[0], 32'hC37F0000);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 600; i++)
            step(1'($urandom), 9'($urandom), 1'($urandom), 9'($urandom),
                 ($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 64) != 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
